// File: rtl/multi_chan_freq_divider.sv
// -----------------------------------------------------------------------------
// multi_chan_freq_divider
//
// NUM_CH independent step-pulse generators. Each channel divides the shared
// clk_en tick stream by its own divisor. It emits one-clk step pulses either
// until stopped (count = 0, free-running) or for exactly `count` pulses,
// after which it pulses done and returns to IDLE.
//
// Ports
//   clk        in   1                  system clock
//   reset      in   1                  synchronous, active-high reset
//   clk_en     in   1                  shared tick; counters advance only when high
//   start      in   NUM_CH             per-channel start request (level-sampled)
//   stop       in   NUM_CH             per-channel synchronous abort
//   div        in   NUM_CH*DIV_BITS    per-channel divisor, ch i at [i*DIV_BITS +: DIV_BITS]
//   count      in   NUM_CH*CNT_BITS    per-channel pulse count, 0 = free-running
//   out        out  NUM_CH             registered step pulse, one clk per period
//   busy       out  NUM_CH             channel is in RUN
//   done       out  NUM_CH             one-clk pulse when a counted run completes
//   remaining  out  NUM_CH*CNT_BITS    pulses left in a counted run, 0 otherwise
// -----------------------------------------------------------------------------
module multi_chan_freq_divider #(
    parameter int NUM_CH   = 2,
    parameter int DIV_BITS = 8,
    parameter int CNT_BITS = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clk_en,
    input  logic [NUM_CH-1:0]            start,
    input  logic [NUM_CH-1:0]            stop,
    input  logic [NUM_CH*DIV_BITS-1:0]   div,
    input  logic [NUM_CH*CNT_BITS-1:0]   count,
    output logic [NUM_CH-1:0]            out,
    output logic [NUM_CH-1:0]            busy,
    output logic [NUM_CH-1:0]            done,
    output logic [NUM_CH*CNT_BITS-1:0]   remaining
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t              state_q, state_d;
        logic [DIV_BITS-1:0] cnt_q, cnt_d;
        logic [DIV_BITS-1:0] div_l_q, div_l_d;
        logic [CNT_BITS-1:0] left_q, left_d;
        logic                out_q, out_d;
        logic                done_q, done_d;
        logic [DIV_BITS-1:0] div_s;
        logic [CNT_BITS-1:0] count_s;

        assign div_s   = div[i*DIV_BITS +: DIV_BITS];
        assign count_s = count[i*CNT_BITS +: CNT_BITS];

        // Channel state and output registers.
        always_ff @(posedge clk) begin
            if (reset) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                div_l_q <= '0;
                left_q  <= '0;
                out_q   <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                div_l_q <= div_l_d;
                left_q  <= left_d;
                out_q   <= out_d;
                done_q  <= done_d;
            end
        end

        // Next-state logic: start acceptance, period counting and abort.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            div_l_d = div_l_q;
            left_d  = left_q;
            out_d   = 1'b0;
            done_d  = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // A zero divisor would never reach a terminal tick, so it is refused.
                    if (start[i] && !stop[i] && (div_s != '0)) begin
                        state_d = ST_RUN;
                        div_l_d = div_s;
                        left_d  = count_s;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (stop[i]) begin
                        // Abort wins over a coincident terminal tick: no pulse, no done.
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        left_d  = '0;
                    end else if (clk_en) begin
                        if (cnt_q == (div_l_q - DIV_BITS'(1))) begin
                            cnt_d = '0;
                            out_d = 1'b1;
                            // New divisor only lands on a period boundary; 0 keeps the old one.
                            if (div_s != '0) begin
                                div_l_d = div_s;
                            end else begin
                                div_l_d = div_l_q;
                            end
                            // left is only non-zero in RUN for a counted run.
                            if (left_q != '0) begin
                                left_d = left_q - CNT_BITS'(1);
                                if (left_q == CNT_BITS'(1)) begin
                                    state_d = ST_IDLE;
                                    done_d  = 1'b1;
                                end else begin
                                    state_d = ST_RUN;
                                end
                            end else begin
                                left_d = left_q;
                            end
                        end else begin
                            cnt_d = cnt_q + DIV_BITS'(1);
                        end
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    left_d  = '0;
                end
            endcase
        end

        assign out[i]                         = out_q;
        assign busy[i]                        = (state_q == ST_RUN);
        assign done[i]                        = done_q;
        assign remaining[i*CNT_BITS +: CNT_BITS] = left_q;
    end

endmodule

// File: tb/tb_multi_chan_freq_divider.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for multi_chan_freq_divider (NUM_CH=2,
// DIV_BITS=8, CNT_BITS=16). Cycle c=0 is the cycle in which start is driven;
// outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_multi_chan_freq_divider;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_en;
    logic [1:0]  start;
    logic [1:0]  stop;
    logic [15:0] div;
    logic [31:0] count;
    wire  [1:0]  out;
    wire  [1:0]  busy;
    wire  [1:0]  done;
    wire  [31:0] remaining;

    int checks = 0;
    int errors = 0;

    multi_chan_freq_divider #(
        .NUM_CH  (2),
        .DIV_BITS(8),
        .CNT_BITS(16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .clk_en   (clk_en),
        .start    (start),
        .stop     (stop),
        .div      (div),
        .count    (count),
        .out      (out),
        .busy     (busy),
        .done     (done),
        .remaining(remaining)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        start  = 2'b00;
        stop   = 2'b00;
        clk_en = 1'b0;
        reset  = 1'b1;
        tick();
        tick();
        reset  = 1'b0;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        start  = 2'b11;
        stop   = 2'b00;
        clk_en = 1'b1;
        div    = 16'h0303;
        count  = 32'h0002_0002;
        tick();
        tick();
        checks++;
        if ({out, busy, done} !== 6'b000000) begin
            errors++;
            $display("FAIL reset_outputs: out/busy/done got %b expected %b", {out, busy, done}, 6'b000000);
        end
        checks++;
        if (remaining !== 32'h0) begin
            errors++;
            $display("FAIL reset_remaining: got %h expected %h", remaining, 32'h0);
        end
        do_reset();
    endtask

    // ch0 div=4 count=3, start at c=0: pulses at 5, 9, 13; done at 13.
    task automatic test_counted();
        logic        eo, eb, ed;
        logic [15:0] er;
        do_reset();
        clk_en    = 1'b1;
        div       = 16'h0004;
        count     = 32'h0000_0003;
        start     = 2'b01;
        for (int c = 1; c <= 17; c++) begin
            tick();
            start = 2'b00;
            eo = (c == 5) || (c == 9) || (c == 13);
            ed = (c == 13);
            eb = (c >= 1) && (c <= 12);
            er = (c <= 4) ? 16'd3 : (c <= 8) ? 16'd2 : (c <= 12) ? 16'd1 : 16'd0;
            checks++;
            if ({out[0], busy[0], done[0]} !== {eo, eb, ed}) begin
                errors++;
                $display("FAIL counted_obd c=%0d: got %b expected %b", c, {out[0], busy[0], done[0]}, {eo, eb, ed});
            end
            checks++;
            if (remaining[15:0] !== er) begin
                errors++;
                $display("FAIL counted_remaining c=%0d: got %0d expected %0d", c, remaining[15:0], er);
            end
        end
    endtask

    // ch1 div=1 free-running: out every cycle from c=2, stop at c=8.
    task automatic test_free_run_stop();
        logic eo;
        do_reset();
        clk_en = 1'b1;
        div    = 16'h0100;
        count  = 32'h0;
        start  = 2'b10;
        for (int c = 1; c <= 12; c++) begin
            tick();
            start = 2'b00;
            stop  = 2'b00;
            eo = (c >= 2) && (c <= 8);
            checks++;
            if ({out[1], busy[1], done[1]} !== {eo, (c <= 8), 1'b0}) begin
                errors++;
                $display("FAIL freerun_obd c=%0d: got %b expected %b", c, {out[1], busy[1], done[1]}, {eo, (c <= 8), 1'b0});
            end
            checks++;
            if (remaining[31:16] !== 16'd0) begin
                errors++;
                $display("FAIL freerun_remaining c=%0d: got %0d expected 0", c, remaining[31:16]);
            end
            if (c == 8) stop = 2'b10;
        end
    endtask

    // ch0 div=2 count=2, clk_en only in cycles c%3==2: pulses at 6 and 12.
    task automatic test_sparse_enable();
        logic        eo, eb, ed;
        logic [15:0] er;
        do_reset();
        clk_en = 1'b0;
        div    = 16'h0002;
        count  = 32'h0000_0002;
        start  = 2'b01;
        for (int c = 1; c <= 15; c++) begin
            tick();
            start  = 2'b00;
            clk_en = ((c % 3) == 2);
            eo = (c == 6) || (c == 12);
            ed = (c == 12);
            eb = (c >= 1) && (c <= 11);
            er = (c <= 5) ? 16'd2 : (c <= 11) ? 16'd1 : 16'd0;
            checks++;
            if ({out[0], busy[0], done[0]} !== {eo, eb, ed}) begin
                errors++;
                $display("FAIL sparse_obd c=%0d: got %b expected %b", c, {out[0], busy[0], done[0]}, {eo, eb, ed});
            end
            checks++;
            if (remaining[15:0] !== er) begin
                errors++;
                $display("FAIL sparse_remaining c=%0d: got %0d expected %0d", c, remaining[15:0], er);
            end
        end
    endtask

    // Free-running div=5; at c=7 div becomes new_div. Period boundary rule
    // gives pulses 6, 11 then every 2 (new_div=2) or every 5 (new_div=0).
    task automatic test_reload(input logic [7:0] new_div);
        logic eo;
        do_reset();
        clk_en = 1'b1;
        div    = 16'h0005;
        count  = 32'h0;
        start  = 2'b01;
        for (int c = 1; c <= 23; c++) begin
            tick();
            start = 2'b00;
            stop  = 2'b00;
            if (c == 7) div = {8'h00, new_div};
            if (new_div == 8'd2)
                eo = (c == 6) || (c == 11) || (c == 13) || (c == 15) || (c == 17) || (c == 19) || (c == 21);
            else
                eo = (c == 6) || (c == 11) || (c == 16) || (c == 21);
            checks++;
            if ({out[0], busy[0], done[0]} !== {eo, (c <= 22), 1'b0}) begin
                errors++;
                $display("FAIL reload_div%0d_obd c=%0d: got %b expected %b", new_div, c, {out[0], busy[0], done[0]}, {eo, (c <= 22), 1'b0});
            end
            if (c == 22) stop = 2'b01;
        end
        stop = 2'b00;
    endtask

    task automatic test_corners();
        // start with div=0 is ignored
        do_reset();
        clk_en = 1'b1;
        div    = 16'h0000;
        count  = 32'h0000_0001;
        start  = 2'b01;
        for (int c = 1; c <= 3; c++) begin
            tick();
            checks++;
            if ({out[0], busy[0], done[0]} !== 3'b000) begin
                errors++;
                $display("FAIL div0_start c=%0d: got %b expected 000", c, {out[0], busy[0], done[0]});
            end
        end
        start = 2'b00;
        // start together with stop stays IDLE
        div   = 16'h0303;
        start = 2'b11;
        stop  = 2'b11;
        for (int c = 1; c <= 3; c++) begin
            tick();
            checks++;
            if ({out, busy, done} !== 6'b000000) begin
                errors++;
                $display("FAIL start_stop_same c=%0d: got %b expected 000000", c, {out, busy, done});
            end
        end
        start = 2'b00;
        stop  = 2'b00;
        // stop coincident with the final terminal tick (div=2 count=1, terminal at c=2)
        do_reset();
        clk_en = 1'b1;
        div    = 16'h0002;
        count  = 32'h0000_0001;
        start  = 2'b01;
        for (int c = 1; c <= 5; c++) begin
            tick();
            start = 2'b00;
            stop  = 2'b00;
            checks++;
            if ({out[0], busy[0], done[0]} !== {1'b0, (c <= 2), 1'b0}) begin
                errors++;
                $display("FAIL stop_on_final c=%0d: got %b expected %b", c, {out[0], busy[0], done[0]}, {1'b0, (c <= 2), 1'b0});
            end
            checks++;
            if (remaining[15:0] !== ((c <= 2) ? 16'd1 : 16'd0)) begin
                errors++;
                $display("FAIL stop_on_final_rem c=%0d: got %0d expected %0d", c, remaining[15:0], (c <= 2) ? 1 : 0);
            end
            if (c == 2) stop = 2'b01;
        end
    endtask

    // ch0 div=3 count=2 (pulses 4,7, done 7); ch1 div=7 free (pulses 8,15,22);
    // reset at c=23 clears everything by c=24.
    task automatic test_independence_reset();
        logic [1:0] eo, eb, ed;
        do_reset();
        clk_en = 1'b1;
        div    = 16'h0703;
        count  = 32'h0000_0002;
        start  = 2'b11;
        for (int c = 1; c <= 23; c++) begin
            tick();
            start = 2'b00;
            eo = {((c == 8) || (c == 15) || (c == 22)), ((c == 4) || (c == 7))};
            eb = {1'b1, (c <= 6)};
            ed = {1'b0, (c == 7)};
            checks++;
            if ({out, busy, done} !== {eo, eb, ed}) begin
                errors++;
                $display("FAIL indep_obd c=%0d: got %b expected %b", c, {out, busy, done}, {eo, eb, ed});
            end
            checks++;
            if (remaining[31:16] !== 16'd0) begin
                errors++;
                $display("FAIL indep_rem1 c=%0d: got %0d expected 0", c, remaining[31:16]);
            end
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int c = 24; c <= 27; c++) begin
            checks++;
            if ({out, busy, done} !== 6'b000000 || remaining !== 32'h0) begin
                errors++;
                $display("FAIL midrun_reset c=%0d: got %b/%h expected 000000/00000000", c, {out, busy, done}, remaining);
            end
            tick();
        end
    endtask

    initial begin
        reset  = 1'b1;
        clk_en = 1'b0;
        start  = 2'b00;
        stop   = 2'b00;
        div    = 16'h0;
        count  = 32'h0;
        test_reset();
        test_counted();
        test_free_run_stop();
        test_sparse_enable();
        test_reload(8'd2);
        test_reload(8'd0);
        test_corners();
        test_independence_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
